// File: rtl/uart_rx_sipo.sv
// UART receive stage: synchronises the serial line, finds the start bit,
// samples each bit at its middle using an oversampled clock and presents the
// recovered word with parity/stop status and a one-cycle done pulse.
module uart_rx_sipo #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       BaudOut,
    input  logic       rst,
    input  logic       data_tx,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_parll,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       stop_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [2:0]             bcnt_q, bcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_acc_q, par_acc_d;
    logic                   perr_q, perr_d;
    logic                   serr_q, serr_d;
    logic [1:0]             cfg_par_q, cfg_par_d;
    logic                   cfg_stop2_q, cfg_stop2_d;
    logic                   cfg_len8_q, cfg_len8_d;
    logic [7:0]             data_q, data_d;
    logic                   perr_out_q, perr_out_d;
    logic                   serr_out_q, serr_out_d;

    logic rxs;
    logic data_last;
    logic par_en;
    logic serr_next;

    assign rxs          = sync_q[SYNC_STAGES-1];
    assign data_last    = cfg_len8_q ? (bcnt_q == 3'd7) : (bcnt_q == 3'd6);
    assign par_en       = (cfg_par_q == 2'b01) || (cfg_par_q == 2'b10);
    assign serr_next    = serr_q | ~rxs;

    assign data_parll   = data_q;
    assign parity_error = perr_out_q;
    assign stop_error   = serr_out_q;

    // Metastability chain: new line value enters at stage 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], data_tx};
    end

    // Frame FSM: next state, bit timing, data assembly and status outputs.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q + TW'(1);
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        par_acc_d   = par_acc_q;
        perr_d      = perr_q;
        serr_d      = serr_q;
        cfg_par_d   = cfg_par_q;
        cfg_stop2_d = cfg_stop2_q;
        cfg_len8_d  = cfg_len8_q;
        data_d      = data_q;
        perr_out_d  = perr_out_q;
        serr_out_d  = serr_out_q;
        rx_active   = 1'b0;
        rx_done     = 1'b0;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (!rxs) begin
                    // Frame settings are frozen here for the whole frame.
                    state_d     = START;
                    bcnt_d      = '0;
                    shift_d     = '0;
                    par_acc_d   = 1'b0;
                    perr_d      = 1'b0;
                    serr_d      = 1'b0;
                    cfg_par_d   = parity_type;
                    cfg_stop2_d = stop_bits;
                    cfg_len8_d  = data_length;
                end
            end
            START: begin
                rx_active = 1'b1;
                if (tcnt_q == T_HALF) begin
                    tcnt_d  = '0;
                    // A high line at mid start bit was only a glitch.
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                rx_active = 1'b1;
                if (tcnt_q == T_FULL) begin
                    tcnt_d    = '0;
                    par_acc_d = par_acc_q ^ rxs;
                    if (data_last) begin
                        bcnt_d  = '0;
                        // 7-bit words are shifted one place further so bit 7 reads 0.
                        shift_d = cfg_len8_q ? {rxs, shift_q[7:1]}
                                             : {1'b0, rxs, shift_q[7:2]};
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        bcnt_d  = bcnt_q + 3'd1;
                        shift_d = {rxs, shift_q[7:1]};
                    end
                end
            end
            PARITY: begin
                rx_active = 1'b1;
                if (tcnt_q == T_FULL) begin
                    tcnt_d  = '0;
                    perr_d  = (cfg_par_q == 2'b01) ? ~(par_acc_q ^ rxs)
                                                   : (par_acc_q ^ rxs);
                    state_d = STOP;
                end
            end
            STOP: begin
                rx_active = 1'b1;
                if (tcnt_q == T_FULL) begin
                    tcnt_d = '0;
                    serr_d = serr_next;
                    if (bcnt_q == {2'b00, cfg_stop2_q}) begin
                        state_d    = DONE;
                        data_d     = shift_q;
                        perr_out_d = perr_q;
                        serr_out_d = serr_next;
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                rx_done = 1'b1;
                tcnt_d  = '0;
                state_d = IDLE;
            end
            default: begin
                tcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge BaudOut or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            perr_q      <= 1'b0;
            serr_q      <= 1'b0;
            cfg_par_q   <= 2'b00;
            cfg_stop2_q <= 1'b0;
            cfg_len8_q  <= 1'b0;
            data_q      <= '0;
            perr_out_q  <= 1'b0;
            serr_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            perr_q      <= perr_d;
            serr_q      <= serr_d;
            cfg_par_q   <= cfg_par_d;
            cfg_stop2_q <= cfg_stop2_d;
            cfg_len8_q  <= cfg_len8_d;
            data_q      <= data_d;
            perr_out_q  <= perr_out_d;
            serr_out_q  <= serr_out_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: drives whole frames bit by bit at
// OVERSAMPLE = 16 and checks the recovered word, status and timing.
module tb_uart_rx_sipo;

    logic       clk;
    logic       rst;
    logic       data_tx;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
    logic [7:0] data_parll;
    logic       rx_active;
    logic       rx_done;
    logic       parity_error;
    logic       stop_error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    logic [7:0] done_log[$];

    uart_rx_sipo #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .BaudOut     (clk),
        .rst         (rst),
        .data_tx     (data_tx),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .data_length (data_length),
        .data_parll  (data_parll),
        .rx_active   (rx_active),
        .rx_done     (rx_done),
        .parity_error(parity_error),
        .stop_error  (stop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed frame, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_log.push_back(data_parll);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_tx = b;
        tick(16);
    endtask

    // One frame, LSB first; flip_cfg changes the config inputs right after the start bit.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                              input logic pbit, input int nstop, input logic last_stop,
                              input logic flip_cfg);
        start_cyc = cyc;
        send_bit(1'b0);
        if (flip_cfg) begin
            parity_type = 2'b00;
            stop_bits   = ~stop_bits;
            data_length = ~data_length;
        end
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        for (int s = 0; s < nstop; s++) send_bit((s == nstop - 1) ? last_stop : 1'b1);
        data_tx = 1'b1;
    endtask

    initial begin
        int d0;
        int base;
        rst = 1'b0;
        data_tx = 1'b1;
        parity_type = 2'b00;
        stop_bits = 1'b0;
        data_length = 1'b1;
        tick(3);
        check("reset data_parll", {24'd0, data_parll}, 32'h0);
        check("reset rx_active", {31'd0, rx_active}, 32'h0);
        check("reset rx_done", {31'd0, rx_done}, 32'h0);
        check("reset parity_error", {31'd0, parity_error}, 32'h0);
        check("reset stop_error", {31'd0, stop_error}, 32'h0);
        rst = 1'b1;
        tick(5);

        // 8N1 0x4A
        d0 = done_cnt;
        send_frame(8'h4A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        tick(4);
        check("8N1 done count", done_cnt - d0, 1);
        check("8N1 data", {24'd0, data_parll}, 32'h4A);
        check("8N1 parity_error", {31'd0, parity_error}, 0);
        check("8N1 stop_error", {31'd0, stop_error}, 0);

        // 8O1 0x4A (three ones): parity bit 0 good, 1 bad
        parity_type = 2'b01;
        d0 = done_cnt;
        send_frame(8'h4A, 8, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        tick(4);
        check("8O1 p0 done count", done_cnt - d0, 1);
        check("8O1 p0 parity_error", {31'd0, parity_error}, 0);
        d0 = done_cnt;
        send_frame(8'h4A, 8, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        tick(4);
        check("8O1 p1 done count", done_cnt - d0, 1);
        check("8O1 p1 parity_error", {31'd0, parity_error}, 1);
        check("8O1 p1 data", {24'd0, data_parll}, 32'h4A);

        // 7E2 0x30, config changed mid-frame must be ignored
        parity_type = 2'b10;
        stop_bits = 1'b1;
        data_length = 1'b0;
        d0 = done_cnt;
        send_frame(8'h30, 7, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        tick(4);
        check("7E2 done count", done_cnt - d0, 1);
        check("7E2 data", {24'd0, data_parll}, 32'h30);
        check("7E2 parity_error", {31'd0, parity_error}, 0);
        // last stop sample at 10.5 bits (168) + 2 sync + 1 detect = 171
        check("7E2 done latency", done_cyc - start_cyc, 171);

        // 3-tick glitch on idle line
        d0 = done_cnt;
        data_tx = 1'b0;
        tick(3);
        data_tx = 1'b1;
        check("glitch rx_active high", {31'd0, rx_active}, 1);
        tick(7);
        check("glitch rx_active before sample", {31'd0, rx_active}, 1);
        tick(1);
        check("glitch rx_active after sample", {31'd0, rx_active}, 0);
        tick(40);
        check("glitch done count", done_cnt - d0, 0);
        check("glitch data held", {24'd0, data_parll}, 32'h30);

        // 8N2 with second stop bit low
        parity_type = 2'b00;
        stop_bits = 1'b1;
        data_length = 1'b1;
        d0 = done_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        data_tx = 1'b1;
        tick(20);
        check("8N2 done count", done_cnt - d0, 1);
        check("8N2 stop_error", {31'd0, stop_error}, 1);
        check("8N2 data", {24'd0, data_parll}, 32'h3C);
        check("8N2 parity_error", {31'd0, parity_error}, 0);

        // Reset in the middle of DATA of the next frame
        d0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        tick(5);
        check("pre-reset rx_active", {31'd0, rx_active}, 1);
        rst = 1'b0;
        #1;
        check("midreset data_parll", {24'd0, data_parll}, 0);
        check("midreset rx_active", {31'd0, rx_active}, 0);
        check("midreset rx_done", {31'd0, rx_done}, 0);
        check("midreset parity_error", {31'd0, parity_error}, 0);
        check("midreset stop_error", {31'd0, stop_error}, 0);
        data_tx = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(200);
        check("after reset done count", done_cnt - d0, 0);

        // Back-to-back 8N1 frames
        stop_bits = 1'b0;
        d0 = done_cnt;
        base = done_log.size();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        tick(4);
        check("b2b done count", done_cnt - d0, 2);
        if (done_log.size() >= base + 2) begin
            check("b2b first data", {24'd0, done_log[base]}, 32'hA5);
            check("b2b second data", {24'd0, done_log[base+1]}, 32'h5A);
        end else begin
            check("b2b frames logged", done_log.size() - base, 2);
        end
        check("b2b final data", {24'd0, data_parll}, 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
